// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the in-order
// pipeline writeback and out-of-band MDU (mul/div) results.
//
// MDU results that cannot write immediately are buffered in a small FIFO and
// drained on cycles the pipeline does not write. Buffered entries that a younger
// pipeline write makes stale are marked cancelled and retire without writing.
//
// Optional feature macro: WB_STARVE_GUARD_EN. When defined, a starvation counter
// forces a one-cycle registered wb_stall so the FIFO head can drain. When
// undefined, wb_stall is tied low.
//
// Parameters:
//   DEPTH        - MDU result FIFO entries (power of two, >= 2)
//   STARVE_LIMIT - pipeline-won cycles with a non-empty FIFO before a forced drain
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   wb_we, wb_wr, wb_wD        - pipeline writeback request
//   mdu_valid, mdu_wr, mdu_wD  - MDU result, accepted when mdu_ready is high
//   mdu_ready                  - FIFO not full (registered state only)
//   wb_stall                   - registered; pipeline holds its WB stage
//   rf_we, rf_wr, rf_wD        - register-file write port (combinational)
//   pend_cnt                   - occupied FIFO entries, cancelled ones included
module rf_wb_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_we,
  input  logic [4:0]                 wb_wr,
  input  logic [31:0]                wb_wD,
  input  logic                       mdu_valid,
  input  logic [4:0]                 mdu_wr,
  input  logic [31:0]                mdu_wD,
  output logic                       mdu_ready,
  output logic                       wb_stall,
  output logic                       rf_we,
  output logic [4:0]                 rf_wr,
  output logic [31:0]                rf_wD,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("rf_wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       ent_wr_q [DEPTH];
  logic [31:0]      ent_wd_q [DEPTH];
  logic [DEPTH-1:0] ent_cancel_q, ent_cancel_d;

  logic empty, full, pw, pop, bypass, push;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(DEPTH));
  // Ready looks only at the registered count, so a full FIFO refuses even while popping.
  assign mdu_ready = !rst && !full;
  assign pw        = wb_we && (wb_wr != 5'd0) && !wb_stall;
  assign pend_cnt  = cnt_q;

  // Write-port arbitration: stall-drain > pipeline > FIFO head > MDU bypass.
  always_comb begin
    rf_we  = 1'b0;
    rf_wr  = 5'd0;
    rf_wD  = 32'd0;
    pop    = 1'b0;
    bypass = 1'b0;
    if (!rst) begin
      if (wb_stall) begin
        pop = !empty;
      end else if (pw) begin
        rf_we = 1'b1;
        rf_wr = wb_wr;
        rf_wD = wb_wD;
      end else if (!empty) begin
        pop = 1'b1;
      end else if (mdu_valid) begin
        // A bypassed result to x0 is accepted and dropped without a write.
        bypass = 1'b1;
        if (mdu_wr != 5'd0) begin
          rf_we = 1'b1;
          rf_wr = mdu_wr;
          rf_wD = mdu_wD;
        end
      end
      if (pop && !ent_cancel_q[rd_ptr_q]) begin
        rf_we = 1'b1;
        rf_wr = ent_wr_q[rd_ptr_q];
        rf_wD = ent_wd_q[rd_ptr_q];
      end
    end
  end

  // A same-cycle result to the register the pipeline is writing is older, hence dead.
  assign push = mdu_valid && mdu_ready && !bypass && (mdu_wr != 5'd0) &&
                !(pw && (mdu_wr == wb_wr));

  always_comb begin
    ent_cancel_d = ent_cancel_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pw && (ent_wr_q[i] == wb_wr)) begin
        ent_cancel_d[i] = 1'b1;
      end
    end
    if (push) begin
      ent_cancel_d[wr_ptr_q] = 1'b0;
    end
  end

  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      ent_cancel_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_wr_q[i] <= 5'd0;
        ent_wd_q[i] <= 32'd0;
      end
    end else begin
      cnt_q        <= cnt_d;
      ent_cancel_q <= ent_cancel_d;
      if (push) begin
        ent_wr_q[wr_ptr_q] <= mdu_wr;
        ent_wd_q[wr_ptr_q] <= mdu_wD;
        wr_ptr_q           <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q;
  logic          stall_q;

  // Counts consecutive pipeline-won cycles with work pending; on hitting the limit
  // the next cycle is a one-shot stall that lets the head drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      if (pw && !empty) begin
        if (starve_q == SW'(STARVE_LIMIT - 1)) begin
          stall_q  <= 1'b1;
          starve_q <= '0;
        end else begin
          starve_q <= starve_q + SW'(1);
        end
      end else begin
        starve_q <= '0;
      end
    end
  end

  assign wb_stall = stall_q;
`else
  assign wb_stall = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_wr;
  logic [31:0] wb_wD;
  logic        mdu_valid;
  logic [4:0]  mdu_wr;
  logic [31:0] mdu_wD;
  logic        mdu_ready;
  logic        wb_stall;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wD;
  logic [1:0]  pend_cnt;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  wr;
    logic [31:0] wd;
  } item_t;

  item_t exp_q[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  rf_wb_arbiter #(
    .DEPTH       (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_we    (wb_we),
    .wb_wr    (wb_wr),
    .wb_wD    (wb_wD),
    .mdu_valid(mdu_valid),
    .mdu_wr   (mdu_wr),
    .mdu_wD   (mdu_wD),
    .mdu_ready(mdu_ready),
    .wb_stall (wb_stall),
    .rf_we    (rf_we),
    .rf_wr    (rf_wr),
    .rf_wD    (rf_wD),
    .pend_cnt (pend_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every RF write must match the oldest expected write, including its cycle.
  always @(negedge clk) begin : monitor
    item_t got;
    item_t want;
    if (rf_we === 1'b1) begin
      got = '{cyc: 32'(cyc), wr: rf_wr, wd: rf_wD};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rf_write_unexpected: got cycle %0d x%0d=0x%0h, required no write",
                 cyc, rf_wr, rf_wD);
      end else begin
        want = exp_q.pop_front();
        chk("rf_write", 96'(got), 96'(want));
      end
    end else begin
      chk("rf_idle_zero", {59'd0, rf_we, rf_wr, rf_wD}, 96'd0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mwr, input logic [31:0] mwd);
    wb_we     = we;
    wb_wr     = wr;
    wb_wD     = wd;
    mdu_valid = mv;
    mdu_wr    = mwr;
    mdu_wD    = mwd;
  endtask

  task automatic expect_wr(input logic [4:0] wr, input logic [31:0] wd);
    exp_q.push_back('{cyc: 32'(cyc), wr: wr, wd: wd});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h5);
    next_cycle();
    #2;
    chk("rst_mdu_ready", 96'(mdu_ready), 96'd0);
    chk("rst_rf_we", 96'(rf_we), 96'd0);
    chk("rst_pend", 96'(pend_cnt), 96'd0);
    chk("rst_stall", 96'(wb_stall), 96'd0);

    next_cycle();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("post_rst_pend", 96'(pend_cnt), 96'd0);
    chk("post_rst_stall", 96'(wb_stall), 96'd0);
    chk("post_rst_ready", 96'(mdu_ready), 96'd1);

    // Bypass
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    expect_wr(5'd5, 32'h1234);
    #2;
    chk("byp_ready", 96'(mdu_ready), 96'd1);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("byp_pend", 96'(pend_cnt), 96'd0);

    // Buffer and drain, full refusal, simultaneous push/pop
    next_cycle();
    drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd7, 32'hA);
    expect_wr(5'd3, 32'h300);
    next_cycle();
    drive(1'b1, 5'd3, 32'h301, 1'b1, 5'd8, 32'hB);
    expect_wr(5'd3, 32'h301);
    #2;
    chk("buf_pend1", 96'(pend_cnt), 96'd1);
    chk("buf_ready1", 96'(mdu_ready), 96'd1);
    next_cycle();
    drive(1'b1, 5'd3, 32'h302, 1'b1, 5'd10, 32'hC);
    expect_wr(5'd3, 32'h302);
    #2;
    chk("buf_pend2", 96'(pend_cnt), 96'd2);
    chk("buf_full_ready", 96'(mdu_ready), 96'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hC);
    expect_wr(5'd7, 32'hA);
    #2;
    chk("full_pop_ready", 96'(mdu_ready), 96'd0);
    next_cycle();
    expect_wr(5'd8, 32'hB);
    #2;
    chk("drain_pend1", 96'(pend_cnt), 96'd1);
    chk("drain_ready", 96'(mdu_ready), 96'd1);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd10, 32'hC);
    #2;
    chk("push_pop_pend", 96'(pend_cnt), 96'd1);
    next_cycle();
    #2;
    chk("drain_pend0", 96'(pend_cnt), 96'd0);

    // Cancel by younger pipeline write, then same-cycle discard
    next_cycle();
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h55);
    expect_wr(5'd4, 32'h44);
    next_cycle();
    drive(1'b1, 5'd9, 32'h66, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd9, 32'h66);
    #2;
    chk("cancel_pend1", 96'(pend_cnt), 96'd1);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("cancel_pop_we", 96'(rf_we), 96'd0);
    chk("cancel_pop_pend", 96'(pend_cnt), 96'd1);
    next_cycle();
    drive(1'b1, 5'd11, 32'h77, 1'b1, 5'd11, 32'h88);
    expect_wr(5'd11, 32'h77);
    #2;
    chk("cancel_done_pend", 96'(pend_cnt), 96'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("same_reg_discard_pend", 96'(pend_cnt), 96'd0);
    chk("same_reg_discard_we", 96'(rf_we), 96'd0);

    // x0 handling
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    #2;
    chk("x0_mdu_ready", 96'(mdu_ready), 96'd1);
    chk("x0_mdu_we", 96'(rf_we), 96'd0);
    next_cycle();
    drive(1'b1, 5'd12, 32'h12, 1'b1, 5'd0, 32'hBEEF);
    expect_wr(5'd12, 32'h12);
    #2;
    chk("x0_mdu_pend", 96'(pend_cnt), 96'd0);
    next_cycle();
    drive(1'b1, 5'd13, 32'h13, 1'b1, 5'd14, 32'hE);
    expect_wr(5'd13, 32'h13);
    #2;
    chk("x0_push_only_pend", 96'(pend_cnt), 96'd0);
    next_cycle();
    drive(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0);
    expect_wr(5'd14, 32'hE);
    #2;
    chk("x0_wb_pend", 96'(pend_cnt), 96'd1);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    chk("x0_wb_drained", 96'(pend_cnt), 96'd0);

    // Starvation: one buffered entry while the pipeline writes every cycle
    next_cycle();
    drive(1'b1, 5'd15, 32'hF0, 1'b1, 5'd16, 32'h16);
    expect_wr(5'd15, 32'hF0);
    #2;
    chk("starve_stall0", 96'(wb_stall), 96'd0);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      drive(1'b1, 5'd15, 32'hF0 + 32'(k), 1'b0, 5'd0, 32'd0);
      expect_wr(5'd15, 32'hF0 + 32'(k));
      #2;
      chk("starve_stall_low", 96'(wb_stall), 96'd0);
      chk("starve_pend", 96'(pend_cnt), 96'd1);
    end
    next_cycle();
    drive(1'b1, 5'd15, 32'hF5, 1'b0, 5'd0, 32'd0);
`ifdef WB_STARVE_GUARD_EN
    expect_wr(5'd16, 32'h16);
    #2;
    chk("starve_stall_high", 96'(wb_stall), 96'd1);
`else
    expect_wr(5'd15, 32'hF5);
    #2;
    chk("starve_stall_tied", 96'(wb_stall), 96'd0);
`endif
    next_cycle();
    expect_wr(5'd15, 32'hF5);
    #2;
    chk("starve_stall_after", 96'(wb_stall), 96'd0);
`ifdef WB_STARVE_GUARD_EN
    chk("starve_pend_after", 96'(pend_cnt), 96'd0);
`else
    chk("starve_pend_after", 96'(pend_cnt), 96'd1);
`endif
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifndef WB_STARVE_GUARD_EN
    expect_wr(5'd16, 32'h16);
`endif
    #2;
    chk("starve_stall_idle", 96'(wb_stall), 96'd0);
    next_cycle();
    #2;
    chk("starve_pend_done", 96'(pend_cnt), 96'd0);

    // Asynchronous reset with two pending entries
    next_cycle();
    drive(1'b1, 5'd17, 32'h170, 1'b1, 5'd18, 32'h18);
    expect_wr(5'd17, 32'h170);
    next_cycle();
    drive(1'b1, 5'd17, 32'h171, 1'b1, 5'd19, 32'h19);
    expect_wr(5'd17, 32'h171);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("pre_rst_we", 96'(rf_we), 96'd1);
    chk("pre_rst_pend", 96'(pend_cnt), 96'd2);
    rst = 1'b1;
    #1;
    chk("arst_rf_we", 96'(rf_we), 96'd0);
    chk("arst_pend", 96'(pend_cnt), 96'd0);
    chk("arst_stall", 96'(wb_stall), 96'd0);
    chk("arst_ready", 96'(mdu_ready), 96'd0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #2;
      chk("post_arst_we", 96'(rf_we), 96'd0);
      chk("post_arst_pend", 96'(pend_cnt), 96'd0);
    end

    next_cycle();
    chk("scoreboard_empty", 96'(exp_q.size()), 96'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
